// File: rtl/rf_trace_buffer.sv
// rf_trace_buffer: captures committed register-file writes (cycle, PC, rd, data) into a
// circular buffer drained over valid/ready. Define PL_TRACE_HALT_EN to enable IF-PC halt detection.
module rf_trace_buffer #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int CW       = 32,
    parameter int DEPTH    = 16,
    parameter int MODE     = 0,
    parameter int HALT_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   wb_we,
    input  logic [4:0]             wb_rd,
    input  logic [DW-1:0]          wb_data,
    input  logic [AW-1:0]          wb_pc,
    input  logic [AW-1:0]          if_pc,
    output logic                   tr_valid,
    input  logic                   tr_ready,
    output logic [CW-1:0]          tr_cycle,
    output logic [AW-1:0]          tr_pc,
    output logic [4:0]             tr_rd,
    output logic [DW-1:0]          tr_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            drop_cnt,
    output logic                   halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;
    localparam int EW = CW + AW + 5 + DW;

    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [NW-1:0] count_r;
    logic [CW-1:0] cycle_r;
    logic          overflow_r;
    logic [15:0]   drop_cnt_r;
    logic          halted_s;

    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          lost_s;
    logic          accept_s;
    logic          rd_adv_s;
    logic [EW-1:0] head_s;

    // Push/pop decode; a push into a full buffer without a pop is "lost" in both modes,
    // but in overwrite mode it is still written and the oldest entry is evicted instead.
    always_comb begin
        full_s   = (count_r == NW'(DEPTH));
        push_s   = en && wb_we && (wb_rd != 5'd0) && !halted_s;
        pop_s    = (count_r != {NW{1'b0}}) && tr_ready;
        lost_s   = push_s && full_s && !pop_s;
        accept_s = push_s && !(lost_s && (MODE == 0));
        rd_adv_s = pop_s || (lost_s && (MODE != 0));
    end

    // Pointers, occupancy, cycle stamp and loss bookkeeping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {NW{1'b0}};
            cycle_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + NW'(accept_s) - NW'(rd_adv_s);
            if (en) begin
                cycle_r <= cycle_r + CW'(1);
            end
            if (lost_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_r <= drop_cnt_r + 16'd1;
                end
            end
        end
    end

    // Entry storage; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (rstn && accept_s) begin
            mem_r[wr_ptr_r] <= {cycle_r, wb_pc, wb_rd, wb_data};
        end
    end

    assign head_s = mem_r[rd_ptr_r];
    assign {tr_cycle, tr_pc, tr_rd, tr_data} = head_s;
    assign tr_valid = (count_r != {NW{1'b0}});
    assign count    = count_r;
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;
    assign halted   = halted_s;

`ifdef PL_TRACE_HALT_EN
    localparam int RW = $clog2(HALT_CYC + 1);

    logic [AW-1:0] prev_pc_r;
    logic [RW-1:0] run_r;
    logic [RW-1:0] run_next_s;
    logic          halted_r;

    // Length of the current run of identical IF PCs, saturating at the halt threshold
    always_comb begin
        if (if_pc == prev_pc_r) begin
            if (run_r == RW'(HALT_CYC - 1)) begin
                run_next_s = run_r;
            end else begin
                run_next_s = run_r + RW'(1);
            end
        end else begin
            run_next_s = {RW{1'b0}};
        end
    end

    // Sticky halt flag, raised on the edge where the run reaches the threshold
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_pc_r <= {AW{1'b0}};
            run_r     <= {RW{1'b0}};
            halted_r  <= 1'b0;
        end else if (en) begin
            prev_pc_r <= if_pc;
            run_r     <= run_next_s;
            if (run_next_s == RW'(HALT_CYC - 1)) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign halted_s = halted_r;
`else
    localparam int unused_halt_cyc = HALT_CYC;
    logic [AW-1:0] unused_if_pc_s;

    assign unused_if_pc_s = if_pc;
    assign halted_s       = 1'b0;
`endif

endmodule

// File: tb/tb_rf_trace_buffer.sv
// Scoreboard bench for rf_trace_buffer: a drop-newest and an overwrite-oldest instance (DEPTH=4)
// share directed + random stimulus and are compared against a queue-based reference model.
module tb_rf_trace_buffer;
    localparam int DW       = 32;
    localparam int AW       = 32;
    localparam int CW       = 8;
    localparam int DEPTH    = 4;
    localparam int HALT_CYC = 4;
    localparam int NW       = 3;
`ifdef PL_TRACE_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] cyc;
        logic [AW-1:0] pc;
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } entry_t;

    typedef struct packed {
        logic [NW-1:0] count;
        logic          ovf;
        logic [15:0]   drop;
        logic          halted;
        logic          valid;
        entry_t        head;
    } stat_t;

    logic clk;
    logic rstn;
    logic en;
    logic wb_we;
    logic [4:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_pc;
    logic [AW-1:0] if_pc;
    logic tr_ready;

    logic [1:0]         tr_valid_a;
    logic [1:0][CW-1:0] tr_cycle_a;
    logic [1:0][AW-1:0] tr_pc_a;
    logic [1:0][4:0]    tr_rd_a;
    logic [1:0][DW-1:0] tr_data_a;
    logic [1:0][NW-1:0] count_a;
    logic [1:0]         overflow_a;
    logic [1:0][15:0]   drop_a;
    logic [1:0]         halted_a;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rf_trace_buffer #(
            .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH), .MODE(g), .HALT_CYC(HALT_CYC)
        ) dut (
            .clk(clk), .rstn(rstn), .en(en), .wb_we(wb_we), .wb_rd(wb_rd),
            .wb_data(wb_data), .wb_pc(wb_pc), .if_pc(if_pc),
            .tr_valid(tr_valid_a[g]), .tr_ready(tr_ready), .tr_cycle(tr_cycle_a[g]),
            .tr_pc(tr_pc_a[g]), .tr_rd(tr_rd_a[g]), .tr_data(tr_data_a[g]),
            .count(count_a[g]), .overflow(overflow_a[g]), .drop_cnt(drop_a[g]),
            .halted(halted_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (index = MODE)
    entry_t        mq  [2][$];
    entry_t        sb  [2][$];
    stat_t         stq [2][$];
    logic          m_ovf  [2];
    logic [15:0]   m_drop [2];
    logic [CW-1:0] m_cyc;
    logic          m_halted;
    logic [AW-1:0] hist [$];

    int n_cmp = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    stat_t  mon_st;
    entry_t mon_e;

    task automatic check(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s mode%0d got=%0h expected=%0h at %0t", name, m, act, exp, $time);
        end
    endtask

    function automatic stat_t snap(input int m);
        stat_t s;
        s.count  = NW'(mq[m].size());
        s.ovf    = m_ovf[m];
        s.drop   = m_drop[m];
        s.halted = m_halted;
        s.valid  = (mq[m].size() != 0);
        s.head   = s.valid ? mq[m][0] : '0;
        return s;
    endfunction

    // Predicts the effect of the coming clock edge from the specification's rules
    task automatic model_step(input logic r_n, input logic e, input logic we, input logic [4:0] rd,
                              input logic [DW-1:0] d, input logic [AW-1:0] pc, input logic rdy,
                              input logic [AW-1:0] ipc);
        entry_t ent;
        bit push;
        bit same;
        if (!r_n) begin
            for (int m = 0; m < 2; m++) begin
                mq[m].delete();
                m_ovf[m]  = 1'b0;
                m_drop[m] = 16'd0;
            end
            m_cyc    = '0;
            m_halted = 1'b0;
            hist.delete();
            hist.push_back('0);
        end else begin
            ent  = '{cyc: m_cyc, pc: pc, rd: rd, data: d};
            push = e && we && (rd != 5'd0) && !m_halted;
            for (int m = 0; m < 2; m++) begin
                if (mq[m].size() != 0 && rdy) sb[m].push_back(mq[m].pop_front());
                if (push) begin
                    if (mq[m].size() < DEPTH) begin
                        mq[m].push_back(ent);
                    end else begin
                        m_ovf[m] = 1'b1;
                        if (m_drop[m] != 16'hFFFF) m_drop[m] = m_drop[m] + 16'd1;
                        if (m == 1) begin
                            void'(mq[m].pop_front());
                            mq[m].push_back(ent);
                        end
                    end
                end
            end
            if (e) begin
                m_cyc = m_cyc + 8'd1;
                if (HALT_EN) begin
                    hist.push_back(ipc);
                    if (hist.size() > HALT_CYC) void'(hist.pop_front());
                    if (hist.size() == HALT_CYC) begin
                        same = 1'b1;
                        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
                        if (same) m_halted = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic r_n, input logic e, input logic we, input logic [4:0] rd,
                         input logic [DW-1:0] d, input logic rdy, input logic [AW-1:0] ipc);
        logic [AW-1:0] pc;
        pc = $urandom;
        rstn = r_n; en = e; wb_we = we; wb_rd = rd; wb_data = d;
        wb_pc = pc; tr_ready = rdy; if_pc = ipc;
        if (mon_en) begin
            for (int m = 0; m < 2; m++) stq[m].push_back(snap(m));
        end
        model_step(r_n, e, we, rd, d, pc, rdy, ipc);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares visible state every cycle and each popped entry against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            for (int m = 0; m < 2; m++) begin
                if (stq[m].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL status_queue mode%0d got=empty expected=entry", m);
                end else begin
                    mon_st = stq[m].pop_front();
                    check("tr_valid", m, 64'(tr_valid_a[m]), 64'(mon_st.valid));
                    check("count", m, 64'(count_a[m]), 64'(mon_st.count));
                    check("overflow", m, 64'(overflow_a[m]), 64'(mon_st.ovf));
                    check("drop_cnt", m, 64'(drop_a[m]), 64'(mon_st.drop));
                    check("halted", m, 64'(halted_a[m]), 64'(mon_st.halted));
                    if (mon_st.valid) begin
                        check("head_cycle", m, 64'(tr_cycle_a[m]), 64'(mon_st.head.cyc));
                        check("head_pc", m, 64'(tr_pc_a[m]), 64'(mon_st.head.pc));
                        check("head_rd", m, 64'(tr_rd_a[m]), 64'(mon_st.head.rd));
                        check("head_data", m, 64'(tr_data_a[m]), 64'(mon_st.head.data));
                    end
                end
                if (rstn && tr_valid_a[m] && tr_ready) begin
                    if (sb[m].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL pop mode%0d got=handshake expected=no_entry at %0t", m, $time);
                    end else begin
                        mon_e = sb[m].pop_front();
                        check("pop_cycle", m, 64'(tr_cycle_a[m]), 64'(mon_e.cyc));
                        check("pop_pc", m, 64'(tr_pc_a[m]), 64'(mon_e.pc));
                        check("pop_rd", m, 64'(tr_rd_a[m]), 64'(mon_e.rd));
                        check("pop_data", m, 64'(tr_data_a[m]), 64'(mon_e.data));
                    end
                end
            end
        end
    end

    initial begin
        logic r_n;
        logic e;
        logic we;
        logic [4:0] rd;
        int rdy_pct;

        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, $urandom);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, $urandom);
        mon_en = 1'b1;

        // Three captures with the consumer stalled, then an x0 write that must be ignored
        drive(1'b1, 1'b1, 1'b1, 5'd1, 32'hAAAA_0001, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd2, 32'hBBBB_0002, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'hCCCC_0003, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, $urandom);
        // Overfill: pushes 4..6 into a 4-deep buffer, then full with push+pop together
        drive(1'b1, 1'b1, 1'b1, 5'd4, 32'hDDDD_0004, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd5, 32'hEEEE_0005, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h1111_0006, 1'b0, $urandom);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h2222_0007, 1'b1, $urandom);
        repeat (6) drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, $urandom);
        // Push into an empty buffer while ready is high, then reset with entries held
        drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h3333_0008, 1'b1, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h4444_0009, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h5555_000A, 1'b0, $urandom);
        drive(1'b0, 1'b1, 1'b1, 5'd11, 32'h6666_000B, 1'b1, $urandom);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, $urandom);

        // Random traffic with the consumer rate shifting between phases
        for (int i = 0; i < 480; i++) begin
            rdy_pct = (i / 120 == 0) ? 20 : (i / 120 == 1) ? 80 : (i / 120 == 2) ? 50 : 5;
            r_n = ($urandom_range(0, 199) != 0);
            e   = ($urandom_range(0, 7) != 0);
            we  = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive(r_n, e, we, rd, $urandom, ($urandom_range(0, 99) < rdy_pct), $urandom);
        end

        // Hold the IF PC: pushes stop once halted (halt build), then the buffer drains
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0000_0010);
        drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h7777_0001, 1'b0, 32'h0000_0010);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 5'd13, $urandom, 1'b0, 32'h0000_0040);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 5'd14, $urandom, 1'b0, 32'h0000_0040);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_0040);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0000_0044);

        mon_en = 1'b0;
        for (int m = 0; m < 2; m++) begin
            check("sb_leftover", m, 64'(sb[m].size()), 64'd0);
            check("status_leftover", m, 64'(stq[m].size()), 64'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
